// File: rtl/buf_port_arb_if.sv
// Request/response bundle between the requesters and the shared buffer port arbiter.
// The arbiter takes the slave side; requesters (or the bench) take the master side.
interface buf_port_arb_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 17,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic [NUM_REQ-1:0]        req_we_i;
  logic [NUM_REQ-1:0]        req_last_i;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
  logic [NUM_REQ*DATA_W-1:0] req_wdata_i;
  logic [NUM_REQ-1:0]        rsp_valid_o;
  logic [DATA_W-1:0]         rsp_rdata_o;

  modport slave (
    input  req_valid_i, req_we_i, req_last_i, req_addr_i, req_wdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o
  );

  modport master (
    output req_valid_i, req_we_i, req_last_i, req_addr_i, req_wdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o
  );
endinterface

// File: rtl/buf_port_arb.sv
// Shares one single-ported buffer among NUM_REQ requesters: fixed-priority or round-robin
// arbitration with burst locking, registered buffer port, read-response tag pipeline.
module buf_port_arb #(
  parameter int NUM_REQ  = 3,
  parameter int ADDR_W   = 17,
  parameter int DATA_W   = 8,
  parameter int RD_LAT   = 1,
  parameter int ARB_MODE = 1
) (
  input  logic                clk,
  input  logic                rst,
  buf_port_arb_if.slave       req,
  output logic                buf_en_o,
  output logic                buf_we_o,
  output logic [ADDR_W-1:0]   buf_addr_o,
  output logic [DATA_W-1:0]   buf_wdata_o,
  input  logic [DATA_W-1:0]   buf_rdata_i,
  output logic [NUM_REQ-1:0]  grant_o,
  input  logic                clr_cnt_i,
  output logic [15:0]         conflict_cnt_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   gidx;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   lock_idx;
  logic               locked;
  logic               accept;
  logic               contention;
  logic               sel_we;
  logic               sel_last;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic [NUM_REQ-1:0] tag_pipe [0:RD_LAT];

  always_comb begin : arbiter
    int cand;
    cand = 0;
    grant = '0;
    gidx  = '0;
    if (!rst) begin
      if (locked) begin
        // A locked burst owner blocks everyone else even when it idles.
        if (req.req_valid_i[lock_idx]) begin
          grant[lock_idx] = 1'b1;
          gidx = lock_idx;
        end
      end else if (ARB_MODE == 0) begin
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
          if (req.req_valid_i[i]) begin
            grant = '0;
            grant[i] = 1'b1;
            gidx = IDX_W'(i);
          end
        end
      end else begin
        // Scan downward so the candidate closest above rr_ptr is written last and wins.
        for (int k = NUM_REQ; k >= 1; k--) begin
          cand = (int'(rr_ptr) + k) % NUM_REQ;
          if (req.req_valid_i[cand]) begin
            grant = '0;
            grant[cand] = 1'b1;
            gidx = IDX_W'(cand);
          end
        end
      end
    end
  end

  always_comb begin : beat_mux
    sel_we    = 1'b0;
    sel_last  = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_we    = req.req_we_i[i];
        sel_last  = req.req_last_i[i];
        sel_addr  = req.req_addr_i[i*ADDR_W +: ADDR_W];
        sel_wdata = req.req_wdata_i[i*DATA_W +: DATA_W];
      end
    end
  end

  assign accept          = |grant;
  assign contention      = |(req.req_valid_i & ~grant);
  assign grant_o         = grant;
  assign req.req_ready_o = grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      locked         <= 1'b0;
      lock_idx       <= '0;
      rr_ptr         <= IDX_W'(NUM_REQ - 1);
      buf_en_o       <= 1'b0;
      buf_we_o       <= 1'b0;
      buf_addr_o     <= '0;
      buf_wdata_o    <= '0;
      conflict_cnt_o <= '0;
    end else begin
      buf_en_o <= accept;
      if (accept) begin
        buf_we_o    <= sel_we;
        buf_addr_o  <= sel_addr;
        buf_wdata_o <= sel_wdata;
        rr_ptr      <= gidx;
        if (sel_last) begin
          locked <= 1'b0;
        end else begin
          locked   <= 1'b1;
          lock_idx <= gidx;
        end
      end
      if (clr_cnt_i) begin
        conflict_cnt_o <= '0;
      end else if (contention && (conflict_cnt_o != 16'hFFFF)) begin
        conflict_cnt_o <= conflict_cnt_o + 16'd1;
      end
    end
  end

  // Stage 0 lines up with buf_en_o; stage RD_LAT lines up with valid buf_rdata_i.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= RD_LAT; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= (accept && !sel_we) ? grant : '0;
      for (int i = 1; i <= RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign req.rsp_valid_o = tag_pipe[RD_LAT];
  assign req.rsp_rdata_o = (|tag_pipe[RD_LAT]) ? buf_rdata_i : '0;

endmodule

// File: tb/tb_buf_port_arb.sv
// Directed bench for buf_port_arb: dut_a is round-robin with RD_LAT=1, dut_b is fixed
// priority with RD_LAT=3; each has a small buffer model returning addr[7:0]^0x5F.
module tb_buf_port_arb;
  logic clk;
  logic rst;
  logic clr_cnt;

  logic        buf_en_a, buf_we_a, buf_en_b, buf_we_b;
  logic [16:0] buf_addr_a, buf_addr_b;
  logic [7:0]  buf_wdata_a, buf_wdata_b, buf_rdata_a, buf_rdata_b;
  logic [2:0]  grant_a, grant_b;
  logic [15:0] cnt_a, cnt_b;

  int checks = 0;
  int failures = 0;

  logic [16:0] rr_addr [3] = '{17'h00100, 17'h00021, 17'h10042};
  logic [2:0]  gap_g [5] = '{3'b010, 3'b000, 3'b010, 3'b001, 3'b000};
  logic        gap_en [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  buf_port_arb_if #(.NUM_REQ(3), .ADDR_W(17), .DATA_W(8)) ifa ();
  buf_port_arb_if #(.NUM_REQ(3), .ADDR_W(17), .DATA_W(8)) ifb ();

  buf_port_arb #(.NUM_REQ(3), .ADDR_W(17), .DATA_W(8), .RD_LAT(1), .ARB_MODE(1)) dut_a (
    .clk(clk), .rst(rst), .req(ifa.slave),
    .buf_en_o(buf_en_a), .buf_we_o(buf_we_a), .buf_addr_o(buf_addr_a),
    .buf_wdata_o(buf_wdata_a), .buf_rdata_i(buf_rdata_a), .grant_o(grant_a),
    .clr_cnt_i(clr_cnt), .conflict_cnt_o(cnt_a)
  );

  buf_port_arb #(.NUM_REQ(3), .ADDR_W(17), .DATA_W(8), .RD_LAT(3), .ARB_MODE(0)) dut_b (
    .clk(clk), .rst(rst), .req(ifb.slave),
    .buf_en_o(buf_en_b), .buf_we_o(buf_we_b), .buf_addr_o(buf_addr_b),
    .buf_wdata_o(buf_wdata_b), .buf_rdata_i(buf_rdata_b), .grant_o(grant_b),
    .clr_cnt_i(clr_cnt), .conflict_cnt_o(cnt_b)
  );

  function automatic logic [7:0] mem_f(input logic [16:0] a);
    return a[7:0] ^ 8'h5F;
  endfunction

  logic [7:0] pa;
  logic [7:0] pb [3];
  always @(posedge clk) begin
    pa    <= mem_f(buf_addr_a);
    pb[0] <= mem_f(buf_addr_b);
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end
  assign buf_rdata_a = pa;
  assign buf_rdata_b = pb[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input int i, input logic v, input logic we, input logic last,
                       input logic [16:0] addr, input logic [7:0] wd);
    ifa.req_valid_i[i] = v;
    ifa.req_we_i[i]    = we;
    ifa.req_last_i[i]  = last;
    ifa.req_addr_i[i*17 +: 17] = addr;
    ifa.req_wdata_i[i*8 +: 8]  = wd;
  endtask

  task automatic set_b(input int i, input logic v, input logic we, input logic last,
                       input logic [16:0] addr, input logic [7:0] wd);
    ifb.req_valid_i[i] = v;
    ifb.req_we_i[i]    = we;
    ifb.req_last_i[i]  = last;
    ifb.req_addr_i[i*17 +: 17] = addr;
    ifb.req_wdata_i[i*8 +: 8]  = wd;
  endtask

  task automatic idle_a();
    for (int i = 0; i < 3; i++) set_a(i, 1'b0, 1'b0, 1'b1, 17'h0, 8'h0);
  endtask

  task automatic idle_b();
    for (int i = 0; i < 3; i++) set_b(i, 1'b0, 1'b0, 1'b1, 17'h0, 8'h0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clr_cnt = 1'b0;
    idle_a();
    idle_b();
    for (int i = 0; i < 3; i++) set_a(i, 1'b1, 1'b0, 1'b1, rr_addr[i], 8'h0);
    #1;
    checks++; if (grant_a !== 3'b000) begin failures++; $display("FAIL reset_grant got=%b exp=000", grant_a); end
    checks++; if (ifa.req_ready_o !== 3'b000) begin failures++; $display("FAIL reset_ready got=%b exp=000", ifa.req_ready_o); end
    step();
    step();
    checks++; if (buf_en_a !== 1'b0 || buf_addr_a !== 17'h0 || buf_wdata_a !== 8'h0) begin
      failures++; $display("FAIL reset_buf en=%b addr=%h wd=%h exp 0", buf_en_a, buf_addr_a, buf_wdata_a); end
    checks++; if (ifa.rsp_valid_o !== 3'b000 || ifa.rsp_rdata_o !== 8'h00) begin
      failures++; $display("FAIL reset_rsp v=%b d=%h exp 0", ifa.rsp_valid_o, ifa.rsp_rdata_o); end
    checks++; if (cnt_a !== 16'h0) begin failures++; $display("FAIL reset_cnt got=%h exp=0", cnt_a); end
    rst = 1'b0;
    idle_a();
    step();
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g, exp_r;
    logic [7:0] exp_d;
    logic       exp_en;
    for (int c = 0; c < 9; c++) begin
      for (int i = 0; i < 3; i++) set_a(i, c < 6, 1'b0, 1'b1, rr_addr[i], 8'h0);
      #1;
      exp_g  = (c < 6) ? 3'(1 << (c % 3)) : 3'b000;
      exp_en = (c >= 1 && c <= 6);
      exp_r  = (c >= 2 && c <= 7) ? 3'(1 << ((c - 2) % 3)) : 3'b000;
      exp_d  = (c >= 2 && c <= 7) ? mem_f(rr_addr[(c - 2) % 3]) : 8'h00;
      checks++; if (grant_a !== exp_g) begin failures++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, grant_a, exp_g); end
      checks++; if (ifa.req_ready_o !== exp_g) begin failures++; $display("FAIL rr_ready c=%0d got=%b exp=%b", c, ifa.req_ready_o, exp_g); end
      checks++; if (cnt_a !== 16'((c < 6) ? c : 6)) begin failures++; $display("FAIL rr_cnt c=%0d got=%0d exp=%0d", c, cnt_a, (c < 6) ? c : 6); end
      checks++; if (buf_en_a !== exp_en) begin failures++; $display("FAIL rr_buf_en c=%0d got=%b exp=%b", c, buf_en_a, exp_en); end
      if (exp_en) begin
        checks++; if (buf_addr_a !== rr_addr[(c - 1) % 3] || buf_we_a !== 1'b0) begin
          failures++; $display("FAIL rr_buf_addr c=%0d got=%h we=%b exp=%h we=0", c, buf_addr_a, buf_we_a, rr_addr[(c - 1) % 3]); end
      end
      checks++; if (ifa.rsp_valid_o !== exp_r) begin failures++; $display("FAIL rr_rsp_valid c=%0d got=%b exp=%b", c, ifa.rsp_valid_o, exp_r); end
      checks++; if (ifa.rsp_rdata_o !== exp_d) begin failures++; $display("FAIL rr_rsp_data c=%0d got=%h exp=%h", c, ifa.rsp_rdata_o, exp_d); end
      step();
    end
  endtask

  task automatic test_burst_lock();
    logic [2:0]  exp_g;
    logic [15:0] exp_c;
    int          kc;
    for (int k = 0; k < 7; k++) begin
      idle_a();
      case (k)
        0: set_a(1, 1'b1, 1'b1, 1'b0, 17'h10, 8'hA0);
        1, 2, 3: begin
          set_a(1, 1'b1, 1'b1, k == 3, 17'(16 + k), 8'(8'hA0 + k));
          set_a(0, 1'b1, 1'b1, 1'b1, 17'h77, 8'h55);
        end
        4: set_a(0, 1'b1, 1'b1, 1'b1, 17'h77, 8'h55);
        default: ;
      endcase
      #1;
      exp_g = (k <= 3) ? 3'b010 : (k == 4) ? 3'b001 : 3'b000;
      kc    = (k < 1) ? 0 : (k > 4) ? 3 : k - 1;
      exp_c = 16'(6 + kc);
      checks++; if (grant_a !== exp_g) begin failures++; $display("FAIL lock_grant k=%0d got=%b exp=%b", k, grant_a, exp_g); end
      checks++; if (cnt_a !== exp_c) begin failures++; $display("FAIL lock_cnt k=%0d got=%0d exp=%0d", k, cnt_a, exp_c); end
      checks++; if (buf_en_a !== (k >= 1 && k <= 5)) begin failures++; $display("FAIL lock_buf_en k=%0d got=%b", k, buf_en_a); end
      if (k >= 1 && k <= 4) begin
        checks++; if (buf_we_a !== 1'b1 || buf_addr_a !== 17'(15 + k) || buf_wdata_a !== 8'(8'h9F + k)) begin
          failures++; $display("FAIL lock_write k=%0d we=%b addr=%h wd=%h exp we=1 addr=%h wd=%h",
                               k, buf_we_a, buf_addr_a, buf_wdata_a, 17'(15 + k), 8'(8'h9F + k)); end
      end
      if (k == 5) begin
        checks++; if (buf_addr_a !== 17'h77 || buf_wdata_a !== 8'h55) begin
          failures++; $display("FAIL lock_req0_write addr=%h wd=%h exp addr=77 wd=55", buf_addr_a, buf_wdata_a); end
      end
      checks++; if (ifa.rsp_valid_o !== 3'b000) begin failures++; $display("FAIL lock_no_rsp k=%0d got=%b exp=000", k, ifa.rsp_valid_o); end
      step();
    end
  endtask

  task automatic test_lock_gap();
    for (int g = 0; g < 5; g++) begin
      idle_a();
      case (g)
        0: set_a(1, 1'b1, 1'b1, 1'b0, 17'h20, 8'h11);
        1: set_a(0, 1'b1, 1'b1, 1'b1, 17'h78, 8'h22);
        2: begin
          set_a(0, 1'b1, 1'b1, 1'b1, 17'h78, 8'h22);
          set_a(1, 1'b1, 1'b1, 1'b1, 17'h21, 8'h12);
        end
        3: set_a(0, 1'b1, 1'b1, 1'b1, 17'h78, 8'h22);
        default: ;
      endcase
      #1;
      checks++; if (grant_a !== gap_g[g]) begin failures++; $display("FAIL gap_grant g=%0d got=%b exp=%b", g, grant_a, gap_g[g]); end
      checks++; if (buf_en_a !== gap_en[g]) begin failures++; $display("FAIL gap_buf_en g=%0d got=%b exp=%b", g, buf_en_a, gap_en[g]); end
      if (g == 3) begin
        checks++; if (buf_addr_a !== 17'h21) begin failures++; $display("FAIL gap_last_addr got=%h exp=21", buf_addr_a); end
      end
      step();
    end
  endtask

  task automatic test_fixed_priority();
    for (int k = 0; k < 5; k++) begin
      idle_b();
      if (k < 4) begin
        set_b(0, 1'b1, 1'b1, 1'b1, 17'h30, 8'h01);
        set_b(2, 1'b1, 1'b1, 1'b1, 17'h32, 8'h02);
      end
      #1;
      checks++; if (grant_b !== ((k < 4) ? 3'b001 : 3'b000)) begin failures++; $display("FAIL fixed_grant k=%0d got=%b", k, grant_b); end
      checks++; if (cnt_b !== 16'(k)) begin failures++; $display("FAIL fixed_cnt k=%0d got=%0d exp=%0d", k, cnt_b, k); end
      if (k >= 1) begin
        checks++; if (buf_en_b !== 1'b1 || buf_addr_b !== 17'h30 || buf_we_b !== 1'b1) begin
          failures++; $display("FAIL fixed_buf k=%0d en=%b addr=%h we=%b exp en=1 addr=30 we=1", k, buf_en_b, buf_addr_b, buf_we_b); end
      end
      step();
    end
  endtask

  task automatic test_read_latency3();
    for (int j = 0; j < 6; j++) begin
      idle_b();
      if (j == 0) set_b(2, 1'b1, 1'b0, 1'b1, 17'h05, 8'h00);
      #1;
      if (j == 0) begin
        checks++; if (grant_b !== 3'b100) begin failures++; $display("FAIL lat3_grant got=%b exp=100", grant_b); end
      end
      if (j == 1) begin
        checks++; if (buf_en_b !== 1'b1 || buf_addr_b !== 17'h05 || buf_we_b !== 1'b0) begin
          failures++; $display("FAIL lat3_buf en=%b addr=%h we=%b exp en=1 addr=05 we=0", buf_en_b, buf_addr_b, buf_we_b); end
      end
      checks++; if (ifb.rsp_valid_o !== ((j == 4) ? 3'b100 : 3'b000)) begin
        failures++; $display("FAIL lat3_rsp_valid j=%0d got=%b", j, ifb.rsp_valid_o); end
      checks++; if (ifb.rsp_rdata_o !== ((j == 4) ? 8'h5A : 8'h00)) begin
        failures++; $display("FAIL lat3_rsp_data j=%0d got=%h", j, ifb.rsp_rdata_o); end
      step();
    end
  endtask

  task automatic test_reset_inflight();
    idle_a(); idle_b();
    set_a(0, 1'b1, 1'b0, 1'b1, 17'h40, 8'h00);
    set_b(0, 1'b1, 1'b0, 1'b1, 17'h41, 8'h00);
    #1;
    step();
    idle_a(); idle_b();
    set_a(1, 1'b1, 1'b1, 1'b0, 17'h42, 8'h33);
    set_b(1, 1'b1, 1'b0, 1'b1, 17'h43, 8'h00);
    #1;
    checks++; if (grant_a !== 3'b010) begin failures++; $display("FAIL inflight_pre_grant got=%b exp=010", grant_a); end
    step();
    idle_a(); idle_b();
    rst = 1'b1;
    #1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) set_a(i, 1'b1, 1'b0, 1'b1, rr_addr[i], 8'h00);
    #1;
    checks++; if (grant_a !== 3'b001) begin failures++; $display("FAIL inflight_grant0 got=%b exp=001", grant_a); end
    checks++; if (cnt_a !== 16'h0 || cnt_b !== 16'h0) begin failures++; $display("FAIL inflight_cnt a=%0d b=%0d exp 0", cnt_a, cnt_b); end
    for (int c = 3; c < 8; c++) begin
      if (c > 3) begin idle_a(); #1; end
      checks++; if (ifb.rsp_valid_o !== 3'b000) begin failures++; $display("FAIL inflight_rsp c=%0d got=%b exp=000", c, ifb.rsp_valid_o); end
      step();
    end
  endtask

  task automatic test_saturate();
    idle_b();
    set_b(0, 1'b1, 1'b1, 1'b1, 17'h50, 8'h01);
    set_b(2, 1'b1, 1'b1, 1'b1, 17'h52, 8'h02);
    repeat (65534) step();
    checks++; if (cnt_b !== 16'hFFFE) begin failures++; $display("FAIL sat_pre got=%h exp=fffe", cnt_b); end
    for (int s = 0; s < 3; s++) begin
      step();
      checks++; if (cnt_b !== 16'hFFFF) begin failures++; $display("FAIL sat_hold s=%0d got=%h exp=ffff", s, cnt_b); end
    end
    clr_cnt = 1'b1;
    step();
    checks++; if (cnt_b !== 16'h0) begin failures++; $display("FAIL sat_clear got=%h exp=0", cnt_b); end
    clr_cnt = 1'b0;
    step();
    checks++; if (cnt_b !== 16'h1) begin failures++; $display("FAIL sat_restart got=%h exp=1", cnt_b); end
    idle_b();
    step();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_burst_lock();
    test_lock_gap();
    test_fixed_priority();
    test_read_latency3();
    test_reset_inflight();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
